// File: rtl/xor8_rr_sched.sv
// Round-robin scheduler sharing one 8-input parity tree among NREQ requesters.
// Optional XOR8_SCHED_STALL_EN adds res_ready back-pressure on the result slot.
module xor8_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [7:0]        res_data,
  output logic              res_parity,
`ifdef XOR8_SCHED_STALL_EN
  input  logic              res_ready,
`endif
  input  logic              cnt_clr,
  output logic [CNTW-1:0]   odd_cnt,
  output logic              busy
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic              res_valid_q, res_valid_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic [7:0]        res_data_q, res_data_d;
  logic              res_parity_q, res_parity_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              cons_ready;
  logic              deliver;
  logic              slot_free;
  logic              accept;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  logic [7:0]        gnt_word;
  logic [2**IDW-1:0] vld_pad;

`ifdef XOR8_SCHED_STALL_EN
  assign cons_ready = res_ready;
`else
  assign cons_ready = 1'b1;
`endif

  assign deliver   = res_valid_q & cons_ready;
  assign slot_free = ~res_valid_q | deliver;
  assign vld_pad   = (2**IDW)'(req_valid);

  // Search starts one past the last grant and wraps at NREQ-1.
  always_comb begin
    logic [IDW:0] sum;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!gnt_found && vld_pad[sum[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) gnt_word = req_data[8*i +: 8];
    end
  end

  assign accept = rst_n & slot_free & gnt_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept & (gnt_idx == IDW'(i));
    end
  end

  always_comb begin
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_data_d   = res_data_q;
    res_parity_d = res_parity_q;
    ptr_d        = ptr_q;
    if (accept) begin
      res_valid_d  = 1'b1;
      res_id_d     = gnt_idx;
      res_data_d   = gnt_word;
      res_parity_d = ^gnt_word;
      ptr_d        = gnt_idx;
    end else if (deliver) begin
      res_valid_d  = 1'b0;
    end
  end

  // Clear wins over a coincident odd delivery; the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (deliver && res_parity_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_data_q   <= '0;
      res_parity_q <= 1'b0;
      ptr_q        <= IDW'(NREQ-1);
      cnt_q        <= '0;
    end else begin
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_data_q   <= res_data_d;
      res_parity_q <= res_parity_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_data   = res_data_q;
  assign res_parity = res_parity_q;
  assign odd_cnt    = cnt_q;
  assign busy       = res_valid_q | (|req_valid);

endmodule

// File: tb/tb_xor8_rr_sched.sv
// Directed bench for xor8_rr_sched: per-cycle reference model plus literal checks.
module tb_xor8_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic              cnt_clr = 1'b0;
  logic              res_ready_tb = 1'b1;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [7:0]        res_data;
  logic              res_parity;
  logic [CNTW-1:0]   odd_cnt;
  logic              busy;

  int n_chk = 0;
  int n_fail = 0;

  xor8_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_data   (res_data),
    .res_parity (res_parity),
`ifdef XOR8_SCHED_STALL_EN
    .res_ready  (res_ready_tb),
`endif
    .cnt_clr    (cnt_clr),
    .odd_cnt    (odd_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a one-entry result slot, a last-grant index and a counter.
  int       m_ptr = NREQ - 1;
  bit       m_valid = 0;
  int       m_id = 0;
  int       m_data = 0;
  bit       m_par = 0;
  int       m_cnt = 0;
  int       n_ptr, n_id, n_data, n_cnt;
  bit       n_valid, n_par;

  always @(negedge clk) begin
    int g;
    int w;
    bit dlv;
    logic [NREQ-1:0] e_ready;
    g = -1;
    e_ready = '0;
    dlv = m_valid && res_ready_tb;
    if (rst_n && (req_valid != 0) && (!m_valid || dlv)) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    if (g >= 0) e_ready[g] = 1'b1;
    check("model_req_ready", 32'(req_ready), 32'(e_ready));
    check("model_res_valid", 32'(res_valid), 32'(m_valid));
    check("model_res_id", 32'(res_id), 32'(m_id));
    check("model_res_data", 32'(res_data), 32'(m_data));
    check("model_res_parity", 32'(res_parity), 32'(m_par));
    check("model_odd_cnt", 32'(odd_cnt), 32'(m_cnt));
    check("model_busy", 32'(busy), 32'(m_valid || (req_valid != 0)));
    n_cnt = cnt_clr ? 0 : ((dlv && m_par && m_cnt < CMAX) ? m_cnt + 1 : m_cnt);
    n_valid = m_valid; n_id = m_id; n_data = m_data; n_par = m_par; n_ptr = m_ptr;
    if (g >= 0) begin
      w = int'(req_data[8*g +: 8]);
      n_valid = 1; n_id = g; n_data = w; n_ptr = g;
      n_par = ($countones(w) % 2) == 1;
    end else if (dlv) begin
      n_valid = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= NREQ - 1; m_valid <= 0; m_id <= 0; m_data <= 0; m_par <= 0; m_cnt <= 0;
    end else begin
      m_ptr <= n_ptr; m_valid <= n_valid; m_id <= n_id; m_data <= n_data;
      m_par <= n_par; m_cnt <= n_cnt;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  logic [7:0] sweep [5];
  logic [4:0] sweep_par;

  initial begin
    sweep[0] = 8'h00; sweep[1] = 8'h01; sweep[2] = 8'hFF; sweep[3] = 8'h80; sweep[4] = 8'h7F;
    sweep_par = 5'b11010;
    tick; tick;
    sample;
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_odd_cnt", 32'(odd_cnt), 32'd0);
    tick;
    rst_n = 1'b1;

    // Single requester
    req_valid = 4'b0010;
    req_data[15:8] = 8'hA5;
    sample;
    check("single_ready", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b0000;
    sample;
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_id", 32'(res_id), 32'd1);
    check("single_data", 32'(res_data), 32'hA5);
    check("single_parity", 32'(res_parity), 32'd0);

    // Mid-stream reset, then first grant must go to requester 0
    req_data = '0;
    req_valid = 4'b1111;
    tick;
    rst_n = 1'b0;
    sample;
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_id", 32'(res_id), 32'd0);
    tick;
    rst_n = 1'b1;
    sample;
    check("postrst_ready", 32'(req_ready), 32'h1);

    // Round robin with all requesters valid
    for (int k = 0; k < 8; k++) begin
      tick;
      sample;
      check("rr_id", 32'(res_id), 32'(k % 4));
    end
    req_valid = 4'b0000;

    // Parity sweep on requester 0
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      req_data[7:0] = sweep[k];
      tick;
      sample;
      check("sweep_parity", 32'(res_parity), 32'(sweep_par[k]));
    end
    req_valid = 4'b0000;
    tick;
    sample;
    check("sweep_odd_cnt", 32'(odd_cnt), 32'd3);
    check("idle_busy", 32'(busy), 32'd0);

`ifdef XOR8_SCHED_STALL_EN
    // Stalled result slot must hold and block new grants
    req_valid = 4'b0001;
    req_data[7:0] = 8'h03;
    res_ready_tb = 1'b0;
    tick;
    req_data[7:0] = 8'h07;
    for (int k = 0; k < 3; k++) begin
      sample;
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_data", 32'(res_data), 32'h03);
      tick;
    end
    res_ready_tb = 1'b1;
    sample;
    check("unstall_ready", 32'(req_ready), 32'h1);
    tick;
    sample;
    check("unstall_data", 32'(res_data), 32'h07);
    req_valid = 4'b0000;
    tick;
`endif

    // Counter saturation and clear priority
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    req_valid = 4'b0001;
    req_data[7:0] = 8'h01;
    repeat (300) tick;
    sample;
    check("cnt_saturate", 32'(odd_cnt), 32'(CMAX));
    cnt_clr = 1'b1;
    tick;
    sample;
    check("cnt_clr_priority", 32'(odd_cnt), 32'd0);
    cnt_clr = 1'b0;
    req_valid = 4'b0000;
    tick;
    sample;
    check("cnt_after_clr", 32'(odd_cnt), 32'd1);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
